// File: rtl/cpu_dbg_pkg.sv
// Shared debug-sequencer definitions: step FSM state encoding and common widths.
package cpu_dbg_pkg;

  localparam int unsigned WORD_W              = 32;
  localparam int unsigned DEFAULT_HALF_PERIOD = 4;
  localparam int unsigned STATE_W             = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    CLK_HI = 2'd1,
    CLK_LO = 2'd2
  } step_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a one-clk rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Pulse is built from flop outputs only, so it is glitch-free for one clk.
  assign rise_c = sync & ~sync_d;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Debug clock sequencer: single-step, run-N and free-run CPU clock generation.
// Define CPU_STEP_CTRL_BP_EN to enable the program-counter breakpoint comparator.
module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_in,
  input  logic              run_in,
  input  logic              halt_in,
  input  logic [CNT_W-1:0]  run_count,
  input  logic              bp_en,
  input  logic [WORD_W-1:0] bp_addr,
  input  logic [WORD_W-1:0] pc,
  output logic              cpu_clk,
  output logic              busy,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(IDLE);
  localparam logic [STATE_W-1:0] S_CLK_HI = STATE_W'(CLK_HI);
  localparam logic [STATE_W-1:0] S_CLK_LO = STATE_W'(CLK_LO);

  logic step_rise_c;
  logic run_rise_c;
  logic halt_rise_c;

  sync_edge u_step_sync (.clk(clk), .reset(reset), .async_in(step_in), .rise_c(step_rise_c));
  sync_edge u_run_sync  (.clk(clk), .reset(reset), .async_in(run_in),  .rise_c(run_rise_c));
  sync_edge u_halt_sync (.clk(clk), .reset(reset), .async_in(halt_in), .rise_c(halt_rise_c));

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [PH_W-1:0]    phase;
  logic [PH_W-1:0]    phase_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   remaining_nxt;
  logic               free_run;
  logic               free_run_nxt;
  logic               halt_pend;
  logic               halt_pend_nxt;
  logic [CNT_W-1:0]   cycle_cnt_nxt;
  logic               bp_hit_nxt;
  logic               bp_match_c;
  logic               phase_last_c;

`ifdef CPU_STEP_CTRL_BP_EN
  assign bp_match_c = bp_en && (pc == bp_addr);
`else
  assign bp_match_c = 1'b0;
`endif

  assign phase_last_c = (phase == PH_W'(HALF_PERIOD - 1));

  // Next-state and datapath update; counters only move at phase/period boundaries.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    remaining_nxt = remaining;
    free_run_nxt  = free_run;
    halt_pend_nxt = halt_pend;
    cycle_cnt_nxt = cycle_cnt;
    bp_hit_nxt    = bp_hit;

    case (state)
      S_IDLE: begin
        halt_pend_nxt = 1'b0;
        if (step_rise_c) begin
          remaining_nxt = CNT_W'(1);
          free_run_nxt  = 1'b0;
          bp_hit_nxt    = 1'b0;
          phase_nxt     = '0;
          state_nxt     = S_CLK_HI;
        end else if (run_rise_c) begin
          remaining_nxt = run_count;
          free_run_nxt  = (run_count == '0);
          bp_hit_nxt    = 1'b0;
          phase_nxt     = '0;
          state_nxt     = S_CLK_HI;
        end
      end

      S_CLK_HI: begin
        if (halt_rise_c) begin
          halt_pend_nxt = 1'b1;
        end
        if (phase_last_c) begin
          phase_nxt = '0;
          state_nxt = S_CLK_LO;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end

      S_CLK_LO: begin
        if (halt_rise_c) begin
          halt_pend_nxt = 1'b1;
        end
        if (phase_last_c) begin
          // Period boundary: count it, then decide whether to continue.
          phase_nxt     = '0;
          cycle_cnt_nxt = cycle_cnt + CNT_W'(1);
          if (!free_run) begin
            remaining_nxt = remaining - CNT_W'(1);
          end
          if (bp_match_c) begin
            bp_hit_nxt = 1'b1;
          end
          if ((!free_run && remaining == CNT_W'(1)) || halt_pend || halt_rise_c || bp_match_c) begin
            halt_pend_nxt = 1'b0;
            state_nxt     = S_IDLE;
          end else begin
            state_nxt = S_CLK_HI;
          end
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end

      default: begin
        halt_pend_nxt = 1'b0;
        phase_nxt     = '0;
        state_nxt     = S_IDLE;
      end
    endcase
  end

  // cpu_clk and busy are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase     <= '0;
      remaining <= '0;
      free_run  <= 1'b0;
      halt_pend <= 1'b0;
      cycle_cnt <= '0;
      cpu_clk   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      remaining <= remaining_nxt;
      free_run  <= free_run_nxt;
      halt_pend <= halt_pend_nxt;
      cycle_cnt <= cycle_cnt_nxt;
      cpu_clk   <= (state_nxt == S_CLK_HI);
      busy      <= (state_nxt != S_IDLE);
    end
  end

`ifdef CPU_STEP_CTRL_BP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_hit <= 1'b0;
    end else begin
      bp_hit <= bp_hit_nxt;
    end
  end
`else
  assign bp_hit = 1'b0;

  logic unused_bp_c;
  assign unused_bp_c = ^{bp_en, bp_addr, pc, bp_hit_nxt, bp_match_c};
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl against a period-level command model.
module tb_cpu_step_ctrl;

  localparam int unsigned HP  = 4;
  localparam int unsigned CW  = 32;
  localparam int          PER = 2 * HP;

`ifdef CPU_STEP_CTRL_BP_EN
  localparam bit BP_BUILT = 1'b1;
`else
  localparam bit BP_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          step_in;
  logic          run_in;
  logic          halt_in;
  logic [CW-1:0] run_count;
  logic          bp_en;
  logic [31:0]   bp_addr;
  logic [31:0]   pc;
  logic          cpu_clk;
  logic          busy;
  logic          bp_hit;
  logic [CW-1:0] cycle_cnt;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_cnt;

  cpu_step_ctrl #(.HALF_PERIOD(HP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .run_in(run_in), .halt_in(halt_in),
    .run_count(run_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_clk(cpu_clk), .busy(busy), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of periods a command issues: first boundary where count, halt or breakpoint stops it.
  function automatic int model_periods(input bit is_step, input logic [31:0] n, input int halt_p,
                                       input bit bp_on, input logic [31:0] pc0,
                                       input logic [31:0] bpa, output bit hit);
    int res;
    bit is_free;
    res     = 0;
    hit     = 1'b0;
    is_free = !is_step && (n == 0);
    for (int p = 1; p <= 64 && res == 0; p++) begin
      bit b;
      b = bp_on && ((pc0 + 32'(4 * p)) == bpa);
      if ((!is_free && p == (is_step ? 1 : int'(n))) || p == halt_p || b) begin
        res = p;
        hit = b;
      end
    end
    return res;
  endfunction

  // Issue one command and watch cpu_clk/busy until the sequencer returns to idle.
  // halt_h/halt_o: raise halt_in at offset halt_o (clks) into period halt_h (0 = no halt).
  task automatic run_cmd(input bit do_step, input bit do_run, input logic [31:0] cnt,
                         input int halt_h, input int halt_o, input bit use_bp,
                         input logic [31:0] bpa, input bit poke);
    int exp_p, halt_eff, first_busy, busy_n, hi_n, shape_err, idx, budget;
    bit exp_hit, done, poke_ok;
    // Halt raised at offset o lands three clks later; it may spill into the next period.
    halt_eff = (halt_h == 0) ? 0 : halt_h + (halt_o + 2) / PER;
    exp_p    = model_periods(do_step, cnt, halt_eff, use_bp && BP_BUILT, pc, bpa, exp_hit);
    poke_ok  = poke && !do_step && exp_p >= 3;
    run_count = cnt;
    bp_en     = use_bp;
    bp_addr   = bpa;
    @(negedge clk);
    step_in = do_step;
    run_in  = do_run;
    first_busy = -1; busy_n = 0; hi_n = 0; shape_err = 0; done = 1'b0;
    budget = PER * (exp_p + 2) + 10;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) begin
        idx = busy_n;
        if (first_busy < 0) first_busy = i;
        if (cpu_clk !== ((idx % PER) < HP)) shape_err++;
        if (cpu_clk === 1'b1) hi_n++;
        if (idx % PER == 0) pc = pc + 32'd4;
        if (halt_h != 0 && idx == (halt_h - 1) * PER + halt_o) halt_in = 1'b1;
        if (poke_ok && idx == PER) step_in = 1'b1;
        if (poke_ok && idx == PER + 4) step_in = 1'b0;
        busy_n++;
      end else begin
        if (cpu_clk !== 1'b0) shape_err++;
        if (first_busy >= 0) done = 1'b1;
      end
    end
    exp_cnt = exp_cnt + CW'(exp_p);
    step_in = 1'b0;
    run_in  = 1'b0;
    halt_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("finished", 64'(done), 64'd1);
    check_eq("latency", 64'(first_busy), 64'd2);
    check_eq("busy_clks", 64'(busy_n), 64'(PER * exp_p));
    check_eq("high_clks", 64'(hi_n), 64'(int'(HP) * exp_p));
    check_eq("waveform", 64'(shape_err), 64'd0);
    check_eq("idle_after", 64'(busy), 64'd0);
    check_eq("cycle_cnt", 64'(cycle_cnt), 64'(exp_cnt));
    check_eq("bp_hit", 64'(bp_hit), 64'(exp_hit));
  endtask

  initial begin
    int active;
    int kind;
    reset = 1'b0; step_in = 1'b0; run_in = 1'b0; halt_in = 1'b0;
    run_count = '0; bp_en = 1'b0; bp_addr = '0; pc = '0; exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_clk", 64'(cpu_clk), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_bp_hit", 64'(bp_hit), 64'd0);
    check_eq("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);

    // Single step, run of 5 with step pokes, free run halted in period 7.
    run_cmd(1'b1, 1'b0, 32'd0, 0, 0, 1'b0, 32'd0, 1'b0);
    run_cmd(1'b0, 1'b1, 32'd5, 0, 0, 1'b0, 32'd0, 1'b1);
    run_cmd(1'b0, 1'b1, 32'd0, 7, 2, 1'b0, 32'd0, 1'b0);

    // Breakpoint at 0x10 from pc=0, then a step that clears bp_hit.
    pc = 32'd0;
    run_cmd(1'b0, 1'b1, 32'd10, 0, 0, 1'b1, 32'h10, 1'b0);
    run_cmd(1'b1, 1'b0, 32'd0, 0, 0, 1'b0, 32'd0, 1'b0);

    // Step and run together; halt in last CLK_LO cycle; halt one clk too late.
    run_cmd(1'b1, 1'b1, 32'd5, 0, 0, 1'b0, 32'd0, 1'b0);
    run_cmd(1'b0, 1'b1, 32'd0, 3, PER - 3, 1'b0, 32'd0, 1'b0);
    run_cmd(1'b0, 1'b1, 32'd0, 3, PER - 2, 1'b0, 32'd0, 1'b0);

    // Halt edge while idle must be ignored.
    @(negedge clk); halt_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("halt_idle_busy", 64'(busy), 64'd0);
    halt_in = 1'b0;
    repeat (3) @(posedge clk);
    run_cmd(1'b0, 1'b1, 32'd2, 0, 0, 1'b0, 32'd0, 1'b0);

    // Randomized commands.
    for (int r = 0; r < 12; r++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: run_cmd(1'b1, 1'b0, 32'($urandom_range(0, 6)), 0, 0, 1'b0, 32'd0, 1'b0);
        1: run_cmd(1'b0, 1'b1, 32'($urandom_range(1, 6)),
                   ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : 0,
                   int'($urandom_range(0, PER - 1)), 1'($urandom_range(0, 1)),
                   pc + 32'(4 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        2: run_cmd(1'b0, 1'b1, 32'd0, int'($urandom_range(1, 6)),
                   int'($urandom_range(0, PER - 1)), 1'($urandom_range(0, 1)),
                   pc + 32'(4 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        default: run_cmd(1'b1, 1'b1, 32'($urandom_range(0, 6)), 0, 0, 1'b0, 32'd0, 1'b0);
      endcase
    end

    // Reset during CLK_HI of the second period of a free run.
    run_count = '0; bp_en = 1'b0;
    @(negedge clk); run_in = 1'b1;
    active = 0;
    for (int i = 0; i < 40 && active <= PER; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) active++;
    end
    reset = 1'b0;
    #1;
    check_eq("midrst_cpu_clk", 64'(cpu_clk), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    run_in = 1'b0;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    active = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || cpu_clk !== 1'b0) active++;
    end
    check_eq("post_rst_quiet", 64'(active), 64'd0);
    check_eq("post_rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    run_cmd(1'b1, 1'b0, 32'd0, 0, 0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Debug clock sequencer that sits directly upstream of the single-cycle CPU and data memory. It turns asynchronous virtual-I/O controls (step, run, halt) into a clean, registered CPU clock. It supports single-step, run-N-cycles and free-run modes, with an optional program-counter breakpoint. It also counts the CPU cycles it has issued so the debug probes can display them.

## Interface
Parameters:
- HALF_PERIOD, 4, clk cycles per cpu_clk high phase and per low phase (≥1)
- CNT_W, 32, width of run_count, remaining counter and cycle_cnt

Ports:
- clk  in  1  free-running board clock
- reset  in  1  asynchronous, active-low reset
- step_in  in  1  async level from VIO; a rising edge requests one CPU cycle
- run_in  in  1  async level; a rising edge requests a run of run_count cycles
- halt_in  in  1  async level; a rising edge stops a run at the next period boundary
- run_count  in  CNT_W  cycles per run; 0 = free-run
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- pc  in  32  current PC from CPU
- cpu_clk  out  1  registered clock to CPU/dmem
- busy  out  1  high while not IDLE
- bp_hit  out  1  sticky: run stopped on breakpoint
- cycle_cnt  out  CNT_W  total cpu_clk periods issued

## Operation
- Inputs step_in/run_in/halt_in each pass through a 2-FF synchronizer and a rising-edge detector. Each edge is a single-clk pulse.
- States: IDLE, CLK_HI, CLK_LO. A phase counter counts 0..HALF_PERIOD-1 in each phase.
- cpu_clk = 1 exactly while in CLK_HI. It is a flop output, never combinational.
- In IDLE:
  - Step edge: remaining←1, free←0, bp_hit←0, go to CLK_HI.
  - Run edge: remaining←run_count, free←(run_count==0), bp_hit←0, go to CLK_HI.
  - Step and run edges in the same cycle: step wins.
  - Halt edge in IDLE: ignored.
- CLK_HI → CLK_LO after HALF_PERIOD cycles.
- At the end of CLK_LO (period boundary):
  - cycle_cnt+1, which wraps modulo 2^CNT_W.
  - remaining−1 unless free.
  - Stop and go to IDLE if any of the following holds:
    - (!free && remaining==1), or
    - halt_pend, or
    - breakpoint match (bp_en && pc==bp_addr; sets bp_hit).
  - Otherwise go to CLK_HI.
- A halt edge in CLK_HI or CLK_LO sets halt_pend. halt_pend is cleared on entry to IDLE. Periods are never truncated.
- Step and run edges outside IDLE are dropped and not queued.
- pc is sampled only at the period boundary. By then it has been stable since the cpu_clk rising edge.
- Breakpoint semantics: the CPU stops with pc==bp_addr, i.e. before that instruction executes. A run started on a breakpoint PC executes at least one cycle.

## Timing
- Reset (async assert, sync deassert via the synchronizers):
  - State IDLE; cpu_clk=0, busy=0, bp_hit=0, cycle_cnt=0.
  - remaining=0, halt_pend=0, synchronizer flops=0.
- Reset mid-run forces cpu_clk low immediately. No partial period is counted.
- Latency: step_in sampled high at clk edge k gives cpu_clk=1 and busy=1 after edge k+2.
- One step = HALF_PERIOD clks high, then HALF_PERIOD clks low. busy drops at the edge that ends CLK_LO.
- Back-to-back periods in a run have no idle gap: the duty cycle is exactly 50%, with period 2·HALF_PERIOD.
- A halt edge detected in the final cycle of CLK_LO takes effect at that same boundary.

## Configuration
- CPU_STEP_CTRL_BP_EN defined: comparator and bp_hit are active as described.
- Undefined:
  - The compare logic is removed.
  - bp_en, bp_addr and pc are ignored; the ports remain.
  - bp_hit is tied to 0.
  - Runs stop only on count or halt.

## Structure
- Shared package cpu_dbg_pkg holds:
  - the state enum (IDLE/CLK_HI/CLK_LO),
  - WORD_W=32,
  - the default HALF_PERIOD constant.
- One sub-module, sync_edge: a 2-FF synchronizer plus registered rising-edge pulse, with async active-low reset. It is instantiated three times.

## Test plan
- Reset, then a step_in pulse → exactly one cpu_clk high of 4 clks then low of 4 clks; cycle_cnt=1, busy=0 afterwards.
- run_count=5 with a run_in edge → 5 contiguous periods (40 clks busy); cycle_cnt +5; step_in edges during the run are ignored.
- run_count=0 with a run edge, then a halt edge mid-CLK_HI of period 7 → period 7 completes, stop; cycle_cnt +7.
- BP_EN: bp_en=1, bp_addr=0x10, pc advances by 4 per cycle from 0 → stops after 4 periods with pc=0x10, bp_hit=1; the next step clears bp_hit.
- Step and run edges in the same clk → single period only.
- reset asserted during CLK_HI of a run → cpu_clk=0 asynchronously, cycle_cnt=0; after release, no activity until a new edge.
